// File: rtl/pipe_field_pkg.sv
// Shared types and constants for the Flappy Bird LED game stages.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOST = 2'd2
  } game_state_t;

  // Feedback taps for x^8+x^6+x^5+x^4+1 with a left-shifting register
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  localparam int unsigned DEF_ROWS = 8;
  localparam int unsigned DEF_COLS = 8;

  // One LFSR step: shift left, parity of tapped bits enters bit 0
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pipe_field_if.sv
// Game-side signals of the pipe stage: bird input, grid/score/status outputs.
interface pipe_field_if
  import flappy_pkg::*;
#(
  parameter int unsigned ROWS = DEF_ROWS,
  parameter int unsigned COLS = DEF_COLS
);

  logic                 start;
  logic [ROWS-1:0]      birdRows;
  logic [ROWS*COLS-1:0] redGrid;
  logic                 lossDetect;
  logic [7:0]           score;
  logic                 playing;

  modport master (
    output start, birdRows,
    input  redGrid, lossDetect, score, playing
  );

  modport slave (
    input  start, birdRows,
    output redGrid, lossDetect, score, playing
  );

endinterface

// File: rtl/pipe_field_gen.sv
// Pipe column generator: LFSR-chosen gap position, everything else lit.
module pipe_gen
  import flappy_pkg::*;
#(
  parameter int unsigned ROWS      = DEF_ROWS,
  parameter int unsigned GAP_H     = 3,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            advance,
  output logic [ROWS-1:0] pipe_col_c
);

  localparam int unsigned SLOTS = ROWS - GAP_H + 1;

  logic [7:0] lfsr;
  logic [7:0] gap_c;

  // Step the LFSR once per inserted pipe; only reset reseeds it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign gap_c = 8'(lfsr % 8'(SLOTS));

  // Open rows gap..gap+GAP_H-1, light all others
  always_comb begin
    pipe_col_c = '1;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if ((32'(gap_c) <= r) && (r < 32'(gap_c) + GAP_H)) begin
        pipe_col_c[r] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_field.sv
// Obstacle stage: scrolls pipe columns across the grid, detects bird collisions
// and counts pipes passed.
module pipe_field
  import flappy_pkg::*;
#(
  parameter int unsigned ROWS         = DEF_ROWS,
  parameter int unsigned COLS         = DEF_COLS,
  parameter int unsigned TICK_DIV     = 1791,
  parameter int unsigned GAP_H        = 3,
  parameter int unsigned PIPE_SPACING = 4,
  parameter int unsigned BIRD_COL     = 1,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic         clock,
  input  logic         reset,
  pipe_field_if.slave  bus
);

  localparam int unsigned GRID_W = ROWS * COLS;
  localparam int unsigned DIV_W  = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam int unsigned SP_W   = $clog2(PIPE_SPACING);

  game_state_t       state;
  logic [DIV_W-1:0]  divider;
  logic [SP_W-1:0]   spacing;
  logic [GRID_W-1:0] grid;
  logic [7:0]        score;
  logic              loss;
  logic              playing;

  logic [ROWS-1:0]   bird_col_c;
  logic [ROWS-1:0]   pipe_col_c;
  logic [ROWS-1:0]   new_col_c;
  logic [GRID_W-1:0] shifted_c;
  logic              collide_c;
  logic              tick_c;
  logic              advance_c;

  // Collision: any bird row over red in the bird column, or no bird at all
  assign bird_col_c = grid[BIRD_COL*ROWS +: ROWS];
  assign collide_c  = (|(bus.birdRows & bird_col_c)) | (bus.birdRows == '0);
  assign tick_c     = (divider == DIV_W'(TICK_DIV));
  assign advance_c  = (state == RUN) && !collide_c && tick_c && (spacing == '0);

  // Scroll left by one column; rightmost column is a fresh pipe or empty
  assign new_col_c = (spacing == '0) ? pipe_col_c : '0;
  assign shifted_c = {new_col_c, grid[GRID_W-1:ROWS]};

  pipe_gen #(
    .ROWS      (ROWS),
    .GAP_H     (GAP_H),
    .LFSR_SEED (LFSR_SEED)
  ) u_gen (
    .clock      (clock),
    .reset      (reset),
    .advance    (advance_c),
    .pipe_col_c (pipe_col_c)
  );

  // Game FSM with divider, spacing counter, grid shift register and score
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      divider <= '0;
      spacing <= '0;
      grid    <= '0;
      score   <= '0;
      loss    <= 1'b0;
      playing <= 1'b0;
    end else begin
      case (state)
        IDLE, LOST: begin
          if (bus.start) begin
            state   <= RUN;
            divider <= '0;
            spacing <= '0;
            grid    <= '0;
            score   <= '0;
            loss    <= 1'b0;
            playing <= 1'b1;
          end
        end
        RUN: begin
          if (collide_c) begin
            // Collision beats a simultaneous tick: grid and score freeze as-is
            state   <= LOST;
            loss    <= 1'b1;
            playing <= 1'b0;
          end else if (tick_c) begin
            divider <= '0;
            grid    <= shifted_c;
            spacing <= (spacing == '0) ? SP_W'(PIPE_SPACING - 1) : spacing - SP_W'(1);
            if ((|bird_col_c) && (score != 8'hFF)) begin
              score <= score + 8'd1;
            end
          end else begin
            divider <= divider + DIV_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          loss    <= 1'b0;
          playing <= 1'b0;
        end
      endcase
    end
  end

  assign bus.redGrid    = grid;
  assign bus.lossDetect = loss;
  assign bus.score      = score;
  assign bus.playing    = playing;

endmodule

// File: tb/tb_pipe_field.sv
// Randomized bench for pipe_field against a behavioural game model.
module tb_pipe_field;

  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int TD      = 3;
  localparam int GAP_H   = 3;
  localparam int SPACING = 4;
  localparam int BC      = 1;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_LOST = 2;

  logic clock;
  logic reset;

  pipe_field_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  pipe_field #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .TICK_DIV     (TD),
    .GAP_H        (GAP_H),
    .PIPE_SPACING (SPACING),
    .BIRD_COL     (BC),
    .LFSR_SEED    (8'hA5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference game state
  int         m_st;
  int         m_div;
  int         m_sp;
  int         m_score;
  logic [7:0] m_lfsr;
  logic [7:0] m_cols [COLS];
  logic       m_loss;
  logic       m_play;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m_grid();
    logic [63:0] g;
    g = '0;
    for (int c = 0; c < COLS; c++) g[c*ROWS +: ROWS] = m_cols[c];
    return g;
  endfunction

  function automatic logic [7:0] pipe_of(input logic [7:0] l);
    int gap;
    int full;
    int hole;
    gap  = int'(l) % (ROWS - GAP_H + 1);
    full = (1 << ROWS) - 1;
    hole = ((1 << GAP_H) - 1) << gap;
    return 8'(full & ~hole);
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    logic fb;
    fb = l[7] ^ l[5] ^ l[4] ^ l[3];
    return {l[6:0], fb};
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_div = 0; m_sp = 0; m_score = 0;
    m_lfsr = 8'hA5; m_loss = 1'b0; m_play = 1'b0;
    for (int c = 0; c < COLS; c++) m_cols[c] = '0;
  endtask

  // Advance the reference by one clock given the inputs seen at that edge
  task automatic model_clock(input logic s, input logic [7:0] b);
    logic collide;
    collide = ((b & m_cols[BC]) != 0) || (b == 0);
    if (m_st == S_IDLE || m_st == S_LOST) begin
      if (s) begin
        m_st = S_RUN; m_div = 0; m_sp = 0; m_score = 0;
        m_loss = 1'b0; m_play = 1'b1;
        for (int c = 0; c < COLS; c++) m_cols[c] = '0;
      end
    end else begin
      if (collide) begin
        m_st = S_LOST; m_loss = 1'b1; m_play = 1'b0;
      end else if (m_div == TD) begin
        m_div = 0;
        if (m_cols[BC] != 0 && m_score < 255) m_score++;
        for (int c = 0; c < COLS - 1; c++) m_cols[c] = m_cols[c+1];
        if (m_sp == 0) begin
          m_cols[COLS-1] = pipe_of(m_lfsr);
          m_lfsr = lfsr_step(m_lfsr);
          m_sp = SPACING - 1;
        end else begin
          m_cols[COLS-1] = '0;
          m_sp--;
        end
      end else begin
        m_div++;
      end
    end
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, "_grid"},  64'(bus.redGrid),    m_grid());
    chk({pfx, "_score"}, 64'(bus.score),      64'(m_score));
    chk({pfx, "_loss"},  64'(bus.lossDetect), 64'(m_loss));
    chk({pfx, "_play"},  64'(bus.playing),    64'(m_play));
  endtask

  task automatic step(input string pfx, input logic s, input logic [7:0] b);
    @(negedge clock);
    bus.start    = s;
    bus.birdRows = b;
    model_clock(s, b);
    @(posedge clock);
    #1;
    check_all(pfx);
  endtask

  // A bird that cannot collide: inside the gap if column BC holds a pipe
  function automatic logic [7:0] safe_bird();
    int off;
    int r;
    off = int'($urandom_range(0, ROWS - 1));
    if (m_cols[BC] == 0) return 8'(1 << off);
    for (int i = 0; i < ROWS; i++) begin
      r = (off + i) % ROWS;
      if (m_cols[BC][r] == 1'b0) return 8'(1 << r);
    end
    return 8'h01;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] snap_grid;
    logic [7:0]  snap_score;
    logic [7:0]  lowbit;
    logic        found;

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.birdRows = 8'h00;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    @(negedge clock);
    reset = 1'b0;

    // Scenario 1: start with bird on row 3
    step("start", 1'b1, 8'h08);
    step("first", 1'b0, 8'h08);
    repeat (4) step("first_tick", 1'b0, safe_bird());
    chk("col7_pipe", 64'(bus.redGrid[7*ROWS +: ROWS]), 64'(pipe_of(8'hA5)));

    // Scenario 2: bird stays in the gap, start pulses ignored in RUN
    for (int i = 0; i < 90; i++) step("safe", 1'($urandom_range(0, 3) == 0), safe_bird());
    chk("still_run", 64'(bus.playing), 64'(1));

    // Scenario 3: overlap red in the bird column
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_cols[BC] != 0) found = 1'b1;
      else step("seek", 1'b0, safe_bird());
    end
    chk("seek_found", 64'(found), 64'(1));
    snap_grid  = m_grid();
    snap_score = 8'(m_score);
    lowbit     = m_cols[BC] & (~m_cols[BC] + 8'd1);
    if (lowbit == 0) lowbit = 8'h00;
    step("hit", 1'b0, lowbit);
    chk("hit_loss", 64'(bus.lossDetect), 64'(1));
    for (int i = 0; i < 6; i++) step("lost_hold", 1'b0, 8'($urandom));
    chk("lost_grid", 64'(bus.redGrid), snap_grid);
    chk("lost_score", 64'(bus.score), 64'(snap_score));

    // Scenario 4: bird vanishes during RUN
    step("restart", 1'b1, 8'h10);
    for (int i = 0; i < 30; i++) step("run2", 1'b0, safe_bird());
    step("nobird", 1'b0, 8'h00);
    chk("nobird_loss", 64'(bus.lossDetect), 64'(1));

    // Scenario 5: collision on the tick edge
    step("restart2", 1'b1, 8'h04);
    for (int i = 0; i < 14; i++) step("run3", 1'b0, safe_bird());
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (m_st == S_RUN && m_div == TD) found = 1'b1;
      else step("to_tick", 1'b0, safe_bird());
    end
    chk("tick_found", 64'(found), 64'(1));
    snap_grid  = m_grid();
    snap_score = 8'(m_score);
    step("tick_hit", 1'b0, 8'h00);
    chk("tick_noshift", 64'(bus.redGrid), snap_grid);
    chk("tick_noscore", 64'(bus.score), 64'(snap_score));
    chk("tick_loss", 64'(bus.lossDetect), 64'(1));

    // Scenario 6: asynchronous reset between edges, then LFSR restarts
    step("restart3", 1'b1, 8'h02);
    for (int i = 0; i < 40; i++) step("run4", 1'b0, safe_bird());
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clock);
    reset = 1'b0;
    step("post_rst", 1'b1, 8'h08);
    for (int i = 0; i < 4; i++) step("post_rst_tick", 1'b0, safe_bird());
    chk("reseed_col7", 64'(bus.redGrid[7*ROWS +: ROWS]), 64'(pipe_of(8'hA5)));
    for (int i = 0; i < 60; i++) step("run5", 1'b0, safe_bird());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
